// File: rtl/ctrl_pkg.sv
// Shared opcode constants, ALUOp encodings, control bundle and FSM states for the
// ID-stage control unit.
package ctrl_pkg;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [6:0] F7MulDiv = 7'b0000001;

  localparam logic [1:0] AluNone   = 2'b00;
  localparam logic [1:0] AluBranch = 2'b01;
  localparam logic [1:0] AluR      = 2'b10;
  localparam logic [1:0] AluImm    = 2'b11;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc;
    logic       regwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic       mul;
  } ctrl_t;

  typedef enum logic [0:0] {
    StRun,
    StMulBusy
  } state_e;

  // All-zero bundle used for bubbles and unknown opcodes.
  function automatic ctrl_t ctrl_none();
    ctrl_t c;
    c = '0;
    return c;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct7 decoder producing the control bundle and source-use flags.
// M-ext recognition is present only when PIPE_CTRL_MULDIV_EN is defined.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [6:0] funct7_i,
  output ctrl_t      ctrl_o,
  output logic       uses_rs1_o,
  output logic       uses_rs2_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o     = ctrl_none();
    uses_rs1_o = 1'b1;
    uses_rs2_o = 1'b0;
    illegal_o  = 1'b0;
    case (op_i)
      OpR: begin
        ctrl_o.aluop    = AluR;
        ctrl_o.regwrite = 1'b1;
        uses_rs2_o      = 1'b1;
`ifdef PIPE_CTRL_MULDIV_EN
        ctrl_o.mul      = (funct7_i == F7MulDiv);
`endif
      end
      OpImm: begin
        ctrl_o.aluop    = AluImm;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      OpLoad: begin
        ctrl_o.aluop    = AluImm;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.memread  = 1'b1;
      end
      OpStore: begin
        ctrl_o.aluop    = AluImm;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.memwrite = 1'b1;
        uses_rs2_o      = 1'b1;
      end
      OpBranch: begin
        ctrl_o.aluop  = AluBranch;
        ctrl_o.branch = 1'b1;
        uses_rs2_o    = 1'b1;
      end
      OpJal: begin
        ctrl_o.jump     = 1'b1;
        ctrl_o.regwrite = 1'b1;
        uses_rs1_o      = 1'b0;
      end
      OpJalr: begin
        ctrl_o.jump     = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      OpLui, OpAuipc: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.regwrite = 1'b1;
        uses_rs1_o      = 1'b0;
      end
      default: begin
        // Unknown opcodes read nothing so they never cause a spurious stall.
        illegal_o  = 1'b1;
        uses_rs1_o = 1'b0;
      end
    endcase
  end

`ifndef PIPE_CTRL_MULDIV_EN
  logic unused_funct7;
  assign unused_funct7 = ^funct7_i;
`endif

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID-stage control unit with ID/EX control register, load-use hazard stall, flush kill flag
// and multi-cycle M-ext hold. M-ext support is enabled by defining PIPE_CTRL_MULDIV_EN.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [6:0]        op_i,
  input  logic [6:0]        funct7_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [1:0]        ex_aluop_o,
  output logic              ex_alusrc_o,
  output logic              ex_regwrite_o,
  output logic              ex_memtoreg_o,
  output logic              ex_memread_o,
  output logic              ex_memwrite_o,
  output logic              ex_branch_o,
  output logic              ex_jump_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              ex_mul_o,
  output logic              ex_mul_done_o,
  output logic              ex_illegal_o
);

  ctrl_t id_ctrl;
  logic  id_uses_rs1;
  logic  id_uses_rs2;
  logic  id_illegal;

  ctrl_decode u_decode (
    .op_i       (op_i),
    .funct7_i   (funct7_i),
    .ctrl_o     (id_ctrl),
    .uses_rs1_o (id_uses_rs1),
    .uses_rs2_o (id_uses_rs2),
    .illegal_o  (id_illegal)
  );

  ctrl_t             ex_ctrl_q, ex_ctrl_d;
  logic              ex_valid_q, ex_valid_d;
  logic              ex_illegal_q, ex_illegal_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              kill_q, kill_d;
  state_e            state_q;
  logic              mul_done_q;

  logic busy;
  logic rs_match;
  logic hazard;
  logic load_bubble;

  assign busy = (state_q == StMulBusy);

  always_comb begin
    rs_match = (id_uses_rs1 && (rs1_i == ex_rd_q)) || (id_uses_rs2 && (rs2_i == ex_rd_q));
    hazard   = ex_valid_q && ex_ctrl_q.memread && (ex_rd_q != '0) && id_valid_i && !kill_q &&
               rs_match;
    load_bubble = !id_valid_i || flush_i || kill_q || hazard;
    // A flush outranks the hazard: the killed instruction need not wait for its operand.
    stall_o  = busy || (hazard && !flush_i);
  end

  always_comb begin
    ex_ctrl_d    = ex_ctrl_q;
    ex_valid_d   = ex_valid_q;
    ex_illegal_d = ex_illegal_q;
    ex_rd_d      = ex_rd_q;
    if (!busy) begin
      if (load_bubble) begin
        ex_ctrl_d    = ctrl_none();
        ex_valid_d   = 1'b0;
        ex_illegal_d = 1'b0;
        ex_rd_d      = '0;
      end else begin
        ex_ctrl_d    = id_ctrl;
        ex_valid_d   = !id_illegal;
        ex_illegal_d = id_illegal;
        ex_rd_d      = id_illegal ? '0 : rd_i;
      end
    end
  end

  // The kill flag only survives while EX is held; any accepting cycle consumes it.
  assign kill_d = busy && (kill_q || flush_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_ctrl_q    <= ctrl_none();
      ex_valid_q   <= 1'b0;
      ex_illegal_q <= 1'b0;
      ex_rd_q      <= '0;
      kill_q       <= 1'b0;
    end else begin
      ex_ctrl_q    <= ex_ctrl_d;
      ex_valid_q   <= ex_valid_d;
      ex_illegal_q <= ex_illegal_d;
      ex_rd_q      <= ex_rd_d;
      kill_q       <= kill_d;
    end
  end

`ifdef PIPE_CTRL_MULDIV_EN
  localparam int unsigned CntW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  logic [CntW-1:0] cnt_q;
  logic            mul_load;

  assign mul_load = !busy && !load_bubble && id_ctrl.mul;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StRun;
      cnt_q      <= '0;
      mul_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          mul_done_q <= 1'b0;
          if (mul_load) begin
            if (MUL_LAT > 1) begin
              state_q <= StMulBusy;
              cnt_q   <= CntW'(MUL_LAT - 1);
            end else begin
              mul_done_q <= 1'b1;
            end
          end
        end
        StMulBusy: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            state_q    <= StRun;
            mul_done_q <= 1'b1;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end
`else
  assign state_q    = StRun;
  assign mul_done_q = 1'b0;
`endif

  assign ex_valid_o    = ex_valid_q;
  assign ex_aluop_o    = ex_ctrl_q.aluop;
  assign ex_alusrc_o   = ex_ctrl_q.alusrc;
  assign ex_regwrite_o = ex_ctrl_q.regwrite;
  assign ex_memtoreg_o = ex_ctrl_q.memtoreg;
  assign ex_memread_o  = ex_ctrl_q.memread;
  assign ex_memwrite_o = ex_ctrl_q.memwrite;
  assign ex_branch_o   = ex_ctrl_q.branch;
  assign ex_jump_o     = ex_ctrl_q.jump;
  assign ex_rd_o       = ex_rd_q;
  assign ex_mul_o      = ex_ctrl_q.mul;
  assign ex_mul_done_o = mul_done_q;
  assign ex_illegal_o  = ex_illegal_q;

endmodule
